// File: rtl/mod31_slot_arbiter.sv
// mod31_slot_arbiter: time-division arbiter over a 31-slot frame.
// Each slot has a programmable owner. The owner is granted when it requests.
// Otherwise the slot is reclaimed round-robin among the other requesters.
// A stop request always lets the current frame run to completion.
module mod31_slot_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            cfg_we,
  input  logic [4:0]      cfg_slot,
  input  logic [IDW-1:0]  cfg_owner,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [4:0]      slot,
  output logic            frame_tick,
  output logic            busy
);

  localparam int unsigned NREQ_U = NREQ;
  localparam logic [4:0]  LAST_SLOT = 5'd30;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_slot;
  logic [4:0]      w_slot_nxt;
  logic            r_frame_tick;
  logic            w_frame_tick_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_rr_nxt;
  logic [IDW-1:0]  r_table [0:30];

  logic            w_active;
  logic            w_last;
  logic [IDW-1:0]  w_owner;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_winner;
  logic            w_found;
  logic            w_reclaim;
  logic [NREQ-1:0] w_gnt;
  logic            w_cfg_ok;

  assign w_active = (r_state != S_IDLE);
  assign w_last   = (r_slot == LAST_SLOT);
  assign w_owner  = r_table[r_slot];
  assign w_cfg_ok = cfg_we && (cfg_slot <= LAST_SLOT) &&
                    ({{(32-IDW){1'b0}}, cfg_owner} < NREQ_U);

  // Next-state, slot counter and frame-tick decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !stop) w_state_nxt = S_RUN;
      S_RUN:   if (stop) w_state_nxt = w_last ? S_IDLE : S_DRAIN;
      S_DRAIN: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // The first RUN cycle keeps slot 0, so the counter only advances once running.
    w_slot_nxt = '0;
    if (w_state_nxt != S_IDLE && w_active)
      w_slot_nxt = w_last ? '0 : r_slot + 5'd1;

    w_frame_tick_nxt = (r_state == S_RUN) && (w_state_nxt == S_RUN) && w_last;
  end

  // Grant selection: slot owner first, else round-robin reclaim from r_rr_ptr.
  always_comb begin
    w_gnt     = '0;
    w_found   = 1'b0;
    w_winner  = '0;
    w_idx     = '0;
    w_reclaim = 1'b0;
    w_rr_nxt  = r_rr_ptr;
    if (w_active) begin
      if (req[w_owner]) begin
        w_gnt[w_owner] = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NREQ_U; i++) begin
          w_idx = IDW'((32'(r_rr_ptr) + i) % NREQ_U);
          if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
          end
        end
        if (w_found) begin
          w_gnt[w_winner] = 1'b1;
          w_reclaim       = 1'b1;
          w_rr_nxt        = IDW'((32'(w_winner) + 32'd1) % NREQ_U);
        end
      end
    end
  end

  // State, counters, round-robin pointer and owner table.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_frame_tick <= 1'b0;
      r_rr_ptr     <= '0;
      for (int unsigned s = 0; s < 31; s++)
        r_table[s] <= IDW'(s % NREQ_U);
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_frame_tick <= w_frame_tick_nxt;
      if (w_reclaim)
        r_rr_ptr <= w_rr_nxt;
      if (w_cfg_ok)
        r_table[cfg_slot] <= cfg_owner;
    end
  end

  assign gnt        = w_gnt;
  assign gnt_valid  = |w_gnt;
  assign slot       = r_slot;
  assign frame_tick = r_frame_tick;
  assign busy       = w_active;

endmodule

// File: tb/tb_mod31_slot_arbiter.sv
// Directed bench for mod31_slot_arbiter with hand-computed expectations.
module tb_mod31_slot_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cfg_we;
  logic [4:0] cfg_slot;
  logic [1:0] cfg_owner;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [4:0] slot;
  logic       frame_tick;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  mod31_slot_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_owner(cfg_owner),
    .req(req), .gnt(gnt), .gnt_valid(gnt_valid), .slot(slot),
    .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_slot = '0; cfg_owner = '0; req = '0;
    #2;

    // T1: reset state, then owner rotation with all requesting and a frame wrap
    do_reset();
    req = 4'b1111;
    #1;
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_slot", 32'(slot), 32'd0);
    chk("t1_rst_gnt", 32'(gnt), 32'd0);
    chk("t1_rst_tick", 32'(frame_tick), 32'd0);
    do_start();
    for (int s = 0; s < 31; s++) begin
      chk("t1_slot", 32'(slot), 32'(s));
      chk("t1_gnt", 32'(gnt), 32'(4'b0001 << (s % 4)));
      chk("t1_tick", 32'(frame_tick), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("t1_wrap_slot", 32'(slot), 32'd0);
    chk("t1_wrap_tick", 32'(frame_tick), 32'd1);
    chk("t1_wrap_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("t1_after_tick", 32'(frame_tick), 32'd0);
    chk("t1_after_slot", 32'(slot), 32'd1);

    // T2: reclaim of idle owners' slots round-robin
    do_reset();
    req = 4'b1010;
    do_start();
    chk("t2_s0", 32'(gnt), 32'b0010); tick();
    chk("t2_s1", 32'(gnt), 32'b0010); tick();
    chk("t2_s2", 32'(gnt), 32'b1000); tick();
    chk("t2_s3", 32'(gnt), 32'b1000); tick();
    chk("t2_s4", 32'(gnt), 32'b0010);

    // T3: owner-table writes, including an out-of-range slot and a same-cycle write
    do_reset();
    cfg_we = 1'b1; cfg_slot = 5'd5;  cfg_owner = 2'd3; tick();
    cfg_slot = 5'd31; cfg_owner = 2'd3; tick();
    cfg_we = 1'b0;
    req = 4'b1001;
    do_start();
    chk("t3_s0", 32'(gnt), 32'b0001); tick();
    chk("t3_s1", 32'(gnt), 32'b0001); tick();
    chk("t3_s2", 32'(gnt), 32'b1000); tick();
    chk("t3_s3", 32'(gnt), 32'b1000); tick();
    chk("t3_s4", 32'(gnt), 32'b0001); tick();
    chk("t3_s5", 32'(gnt), 32'b1000); tick();
    cfg_we = 1'b1; cfg_slot = 5'd7; cfg_owner = 2'd0;
    #1;
    chk("t3_s6", 32'(gnt), 32'b0001);
    tick();
    cfg_slot = 5'd7; cfg_owner = 2'd1;
    #1;
    chk("t3_s7_same_cycle", 32'(gnt), 32'b0001);
    tick();
    cfg_we = 1'b0;
    chk("t3_s8", 32'(gnt), 32'b0001);

    // T4: stop mid-frame drains to slot 30, start ignored while draining
    do_reset();
    req = 4'b1111;
    do_start();
    repeat (10) tick();
    chk("t4_slot10", 32'(slot), 32'd10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int s = 11; s < 31; s++) begin
      start = (s == 20);
      #1;
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_slot", 32'(slot), 32'(s));
      chk("t4_gnt", 32'(gnt), 32'(4'b0001 << (s % 4)));
      tick();
    end
    start = 1'b0;
    #1;
    chk("t4_end_busy", 32'(busy), 32'd0);
    chk("t4_end_slot", 32'(slot), 32'd0);
    chk("t4_end_gnt", 32'(gnt), 32'd0);
    chk("t4_end_tick", 32'(frame_tick), 32'd0);
    tick();
    chk("t4_stays_idle", 32'(busy), 32'd0);

    // T5: stop beats start in IDLE; reset mid-frame reloads the table
    start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    #1;
    chk("t5_both_busy", 32'(busy), 32'd0);
    chk("t5_both_gnt", 32'(gnt), 32'd0);
    cfg_we = 1'b1; cfg_slot = 5'd1; cfg_owner = 2'd3; tick();
    cfg_we = 1'b0;
    do_start();
    repeat (17) tick();
    chk("t5_slot17", 32'(slot), 32'd17);
    do_reset();
    #1;
    chk("t5_rst_slot", 32'(slot), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    req = 4'b1010;
    do_start();
    chk("t5_s0", 32'(gnt), 32'b0010); tick();
    chk("t5_s1_reloaded", 32'(gnt), 32'b0010);

    // T6: no requests leaves grants idle and rr_ptr untouched
    do_reset();
    req = 4'b0000;
    do_start();
    for (int s = 0; s < 4; s++) begin
      chk("t6_valid", 32'(gnt_valid), 32'd0);
      chk("t6_slot", 32'(slot), 32'(s));
      tick();
    end
    req = 4'b1110;
    #1;
    chk("t6_s4_rr", 32'(gnt), 32'b0010);
    chk("t6_s4_valid", 32'(gnt_valid), 32'd1);

    // Stop in RUN exactly at slot 30 returns straight to IDLE
    req = 4'b1111;
    repeat (26) tick();
    chk("t6_slot30", 32'(slot), 32'd30);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
    chk("t6_stop30_busy", 32'(busy), 32'd0);
    chk("t6_stop30_tick", 32'(frame_tick), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
